// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Optional build macro: MULDIV_SINGLE_CYCLE_MUL_EN (single-cycle multiply path).
package muldiv_pkg;

  localparam int MD_XLEN       = 32;
  localparam int MD_HART_ID_W  = 1;
  localparam int MD_REG_ADDR_W = 5;

  localparam logic [5:0] ITER_COUNT = 6'd32;

  // RV32M funct3 encodings
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'd0,
    MD_RUN    = 2'd1,
    MD_FINISH = 2'd2
  } md_state_e;

  // rs1 is treated as two's complement for these ops
  function automatic logic op_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is treated as two's complement for these ops
  function automatic logic op_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/div_iter_core.sv
// Restoring radix-2 divider datapath working on unsigned magnitudes.
// One quotient bit per step_en cycle; XLEN steps give final quotient/remainder.
// A zero divisor naturally yields an all-ones quotient and remainder = dividend.
module div_iter_core #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            step_en,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  logic [XLEN-1:0] divisor_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] rem_r;
  logic [XLEN:0]   shifted_s;
  logic [XLEN:0]   diff_s;

  // Trial subtraction: shift next dividend bit into the partial remainder
  always_comb begin
    shifted_s = {rem_r, quo_r[XLEN-1]};
    diff_s    = shifted_s - {1'b0, divisor_r};
  end

  // Quotient/remainder shift register; borrow in diff_s[XLEN] means restore
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divisor_r <= {XLEN{1'b0}};
      quo_r     <= {XLEN{1'b0}};
      rem_r     <= {XLEN{1'b0}};
    end else if (load) begin
      divisor_r <= divisor;
      quo_r     <= dividend;
      rem_r     <= {XLEN{1'b0}};
    end else if (step_en) begin
      if (diff_s[XLEN]) begin
        rem_r <= shifted_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b0};
      end else begin
        rem_r <= diff_s[XLEN-1:0];
        quo_r <= {quo_r[XLEN-2:0], 1'b1};
      end
    end
  end

  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/mul_div_unit.sv
// Shared iterative RV32M multiply/divide unit with hart/rd tagging.
// Optional build macro: MULDIV_SINGLE_CYCLE_MUL_EN -- multiplies complete in
// one step via a combinational 33x33 signed multiplier; divides stay iterative.
// Note: rst_n is an active-HIGH asynchronous reset (historical port name).
import muldiv_pkg::*;

module mul_div_unit #(
  parameter int XLEN       = MD_XLEN,
  parameter int HART_ID_W  = MD_HART_ID_W,
  parameter int REG_ADDR_W = MD_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  muldiv_start,
  input  logic [2:0]            muldiv_op,
  input  logic [XLEN-1:0]       muldiv_a,
  input  logic [XLEN-1:0]       muldiv_b,
  input  logic [HART_ID_W-1:0]  muldiv_hart_id,
  input  logic [REG_ADDR_W-1:0] muldiv_rd,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [XLEN-1:0]       muldiv_result,
  output logic [HART_ID_W-1:0]  muldiv_done_hart_id,
  output logic [REG_ADDR_W-1:0] muldiv_done_rd
);

  md_state_e              state_r;
  logic [2:0]             op_r;
  logic [5:0]             cnt_r;
  logic                   neg_res_r;
  logic                   neg_rem_r;
  logic                   div_zero_r;
  logic [XLEN-1:0]        mcand_r;
  logic [2*XLEN-1:0]      prod_r;
  logic [HART_ID_W-1:0]   hart_r;
  logic [REG_ADDR_W-1:0]  rd_r;
  logic                   busy_r;
  logic                   done_r;
  logic [XLEN-1:0]        result_r;
  logic [HART_ID_W-1:0]   done_hart_r;
  logic [REG_ADDR_W-1:0]  done_rd_r;

  logic                   accept_s;
  logic                   sign_a_s;
  logic                   sign_b_s;
  logic [XLEN-1:0]        mag_a_s;
  logic [XLEN-1:0]        mag_b_s;
  logic [XLEN:0]          mul_sum_s;
  logic [2*XLEN-1:0]      prod_fix_s;
  logic [XLEN-1:0]        quo_fix_s;
  logic [XLEN-1:0]        rem_fix_s;
  logic [XLEN-1:0]        res_s;
  logic [XLEN-1:0]        div_quo_s;
  logic [XLEN-1:0]        div_rem_s;

  // Operand magnitudes and sign flags for the op presented at accept
  always_comb begin
    accept_s = (state_r == MD_IDLE) && muldiv_start;
    sign_a_s = op_a_signed(muldiv_op) & muldiv_a[XLEN-1];
    sign_b_s = op_b_signed(muldiv_op) & muldiv_b[XLEN-1];
    mag_a_s  = sign_a_s ? -muldiv_a : muldiv_a;
    mag_b_s  = sign_b_s ? -muldiv_b : muldiv_b;
  end

  div_iter_core #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst_n),
    .load      (accept_s),
    .step_en   (state_r == MD_RUN),
    .dividend  (mag_a_s),
    .divisor   (mag_b_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // One shift-add step: add multiplicand into the upper half when LSB is set
  always_comb begin
    mul_sum_s = {1'b0, prod_r[2*XLEN-1:XLEN]}
              + (prod_r[0] ? {1'b0, mcand_r} : {(XLEN+1){1'b0}});
  end

`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
  logic [XLEN-1:0]          a_raw_r;
  logic [XLEN-1:0]          b_raw_r;
  logic signed [XLEN:0]     fa_s;
  logic signed [XLEN:0]     fb_s;
  logic signed [2*XLEN+1:0] fprod_s;

  // Raw operands kept for the combinational multiplier
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      a_raw_r <= {XLEN{1'b0}};
      b_raw_r <= {XLEN{1'b0}};
    end else if (accept_s) begin
      a_raw_r <= muldiv_a;
      b_raw_r <= muldiv_b;
    end
  end

  // 33x33 signed product; the extra bit selects signed/unsigned per operand
  always_comb begin
    fa_s    = signed'({op_a_signed(op_r) & a_raw_r[XLEN-1], a_raw_r});
    fb_s    = signed'({op_b_signed(op_r) & b_raw_r[XLEN-1], b_raw_r});
    fprod_s = (2*XLEN+2)'(fa_s) * (2*XLEN+2)'(fb_s);
  end
`endif

  // Sign correction and result selection for the finishing op
  always_comb begin
    prod_fix_s = neg_res_r ? -prod_r : prod_r;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    prod_fix_s = fprod_s[2*XLEN-1:0];
`endif
    quo_fix_s  = neg_res_r ? -div_quo_s : div_quo_s;
    rem_fix_s  = neg_rem_r ? -div_rem_s : div_rem_s;
    case (op_r)
      MD_MUL:                       res_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: res_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              res_s = div_zero_r ? {XLEN{1'b1}} : quo_fix_s;
      MD_REM, MD_REMU:              res_s = rem_fix_s;
      default:                      res_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM, multiply datapath, tags and registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r     <= MD_IDLE;
      op_r        <= 3'd0;
      cnt_r       <= 6'd0;
      neg_res_r   <= 1'b0;
      neg_rem_r   <= 1'b0;
      div_zero_r  <= 1'b0;
      mcand_r     <= {XLEN{1'b0}};
      prod_r      <= {(2*XLEN){1'b0}};
      hart_r      <= {HART_ID_W{1'b0}};
      rd_r        <= {REG_ADDR_W{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= {XLEN{1'b0}};
      done_hart_r <= {HART_ID_W{1'b0}};
      done_rd_r   <= {REG_ADDR_W{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        MD_IDLE: begin
          if (muldiv_start) begin
            op_r       <= muldiv_op;
            hart_r     <= muldiv_hart_id;
            rd_r       <= muldiv_rd;
            neg_res_r  <= sign_a_s ^ sign_b_s;
            neg_rem_r  <= sign_a_s;
            div_zero_r <= (muldiv_b == {XLEN{1'b0}});
            mcand_r    <= mag_a_s;
            prod_r     <= {{XLEN{1'b0}}, mag_b_s};
            cnt_r      <= ITER_COUNT;
            busy_r     <= 1'b1;
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
            state_r    <= muldiv_op[2] ? MD_RUN : MD_FINISH;
`else
            state_r    <= MD_RUN;
`endif
          end
        end
        MD_RUN: begin
          prod_r <= {mul_sum_s, prod_r[XLEN-1:1]};
          cnt_r  <= cnt_r - 6'd1;
          if (cnt_r == 6'd1) begin
            state_r <= MD_FINISH;
          end
        end
        MD_FINISH: begin
          result_r    <= res_s;
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          done_hart_r <= hart_r;
          done_rd_r   <= rd_r;
          state_r     <= MD_IDLE;
        end
        default: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign muldiv_busy         = busy_r;
  assign muldiv_done         = done_r;
  assign muldiv_result       = result_r;
  assign muldiv_done_hart_id = done_hart_r;
  assign muldiv_done_rd      = done_rd_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: an arithmetic reference model with
// cycle-level expectations checked every cycle, plus hand-computed vectors.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        muldiv_start = 1'b0;
  logic [2:0]  muldiv_op = 3'd0;
  logic [31:0] muldiv_a = 32'd0;
  logic [31:0] muldiv_b = 32'd0;
  logic        muldiv_hart_id = 1'b0;
  logic [4:0]  muldiv_rd = 5'd0;
  logic        muldiv_busy;
  logic        muldiv_done;
  logic [31:0] muldiv_result;
  logic        muldiv_done_hart_id;
  logic [4:0]  muldiv_done_rd;

  int errors = 0;
  int checks = 0;

  mul_div_unit dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .muldiv_start        (muldiv_start),
    .muldiv_op           (muldiv_op),
    .muldiv_a            (muldiv_a),
    .muldiv_b            (muldiv_b),
    .muldiv_hart_id      (muldiv_hart_id),
    .muldiv_rd           (muldiv_rd),
    .muldiv_busy         (muldiv_busy),
    .muldiv_done         (muldiv_done),
    .muldiv_result       (muldiv_result),
    .muldiv_done_hart_id (muldiv_done_hart_id),
    .muldiv_done_rd      (muldiv_done_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op);
`ifdef MULDIV_SINGLE_CYCLE_MUL_EN
    return op[2] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Reference model: edge count of accept and completion, expected tags
  int          edge_n = 0;
  bit          pend = 1'b0;
  int          done_edge = 0;
  logic [31:0] exp_res = 32'd0;
  logic [31:0] last_res = 32'd0;
  logic        exp_hart = 1'b0;
  logic [4:0]  exp_rd = 5'd0;

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      edge_n   = 0;
      pend     = 1'b0;
      last_res = 32'd0;
    end else begin
      edge_n++;
      if (pend && edge_n == done_edge) last_res = exp_res;
      if (pend && edge_n > done_edge) pend = 1'b0;
      if (!pend && muldiv_start) begin
        pend      = 1'b1;
        done_edge = edge_n + latency(muldiv_op);
        exp_res   = ref_op(muldiv_op, muldiv_a, muldiv_b);
        exp_hart  = muldiv_hart_id;
        exp_rd    = muldiv_rd;
      end
    end
  end

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    logic exp_busy, exp_done;
    exp_busy = pend && (edge_n < done_edge);
    exp_done = pend && (edge_n == done_edge);
    check("busy", {31'd0, muldiv_busy}, {31'd0, exp_busy});
    check("done", {31'd0, muldiv_done}, {31'd0, exp_done});
    check("result", muldiv_result, last_res);
    if (exp_done) begin
      check("done_hart", {31'd0, muldiv_done_hart_id}, {31'd0, exp_hart});
      check("done_rd", {27'd0, muldiv_done_rd}, {27'd0, exp_rd});
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic h, input logic [4:0] r);
    muldiv_op      = op;
    muldiv_a       = a;
    muldiv_b       = b;
    muldiv_hart_id = h;
    muldiv_rd      = r;
    muldiv_start   = 1'b1;
    @(negedge clk);
    muldiv_start   = 1'b0;
  endtask

  // Wait (bounded) for done; returns in the done cycle at a falling edge
  task automatic wait_done(input string name, input logic [31:0] exp, input logic h,
                           input logic [4:0] r, output int n);
    n = 0;
    while (!muldiv_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!muldiv_done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done within 40 cycles", name);
    end else begin
      check(name, muldiv_result, exp);
      check({name, "_hart"}, {31'd0, muldiv_done_hart_id}, {31'd0, h});
      check({name, "_rd"}, {27'd0, muldiv_done_rd}, {27'd0, r});
      check({name, "_busy"}, {31'd0, muldiv_busy}, 32'd0);
    end
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic h, input logic [4:0] r,
                     input logic [31:0] exp);
    int n;
    check({name, "_model"}, ref_op(op, a, b), exp);
    issue(op, a, b, h, r);
    wait_done(name, exp, h, r, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, muldiv_busy}, 32'd0);
    check("rst_done", {31'd0, muldiv_done}, 32'd0);
    check("rst_result", muldiv_result, 32'd0);
    check("rst_tags", {26'd0, muldiv_done_hart_id, muldiv_done_rd}, 32'd0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // MUL with latency check, then DIV and REM chained in done cycles
    check("mul_model", ref_op(3'd0, 32'd10, 32'd3), 32'd30);
    issue(3'd0, 32'd10, 32'd3, 1'b0, 5'd3);
    wait_done("mul_10x3", 32'd30, 1'b0, 5'd3, n);
    check("mul_latency", n, latency(3'd0));
    issue(3'd4, 32'd10, 32'd3, 1'b1, 5'd5);
    wait_done("div_10_3", 32'd3, 1'b1, 5'd5, n);
    check("div_latency", n, 32'd33);
    issue(3'd6, 32'd10, 32'd3, 1'b0, 5'd7);
    wait_done("rem_10_3", 32'd1, 1'b0, 5'd7, n);
    @(negedge clk);

    // Signed corners
    run("div_m7_2",   3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd8,  32'hFFFF_FFFD);
    run("rem_m7_2",   3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 5'd9,  32'hFFFF_FFFF);
    run("mulh_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 1'b1, 5'd10, 32'h4000_0000);
    run("mulhu_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 5'd11, 32'hFFFF_FFFE);
    run("mulhsu_m1",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd12, 32'hFFFF_FFFF);
    run("mul_neg",    3'd0, 32'hFFFF_FFFE, 32'd7, 1'b0, 5'd13, 32'hFFFF_FFF2);

    // Divide by zero and signed overflow
    run("divu_5_0",   3'd5, 32'd5, 32'd0, 1'b1, 5'd14, 32'hFFFF_FFFF);
    run("remu_5_0",   3'd7, 32'd5, 32'd0, 1'b0, 5'd15, 32'd5);
    run("div_m5_0",   3'd4, 32'hFFFF_FFFB, 32'd0, 1'b1, 5'd16, 32'hFFFF_FFFF);
    run("rem_m5_0",   3'd6, 32'hFFFF_FFFB, 32'd0, 1'b0, 5'd17, 32'hFFFF_FFFB);
    run("div_ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd18, 32'h8000_0000);
    run("rem_ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 5'd19, 32'd0);

    // start while busy is ignored; operand changes after accept are ignored
    issue(3'd4, 32'd100, 32'd7, 1'b0, 5'd9);
    repeat (4) @(negedge clk);
    muldiv_op      = 3'd0;
    muldiv_a       = 32'd3;
    muldiv_b       = 32'd3;
    muldiv_hart_id = 1'b1;
    muldiv_rd      = 5'd1;
    muldiv_start   = 1'b1;
    @(negedge clk);
    muldiv_start   = 1'b0;
    wait_done("busy_ignore", 32'd14, 1'b0, 5'd9, n);
    repeat (40) @(negedge clk);

    // Asynchronous reset in the middle of a divide
    issue(3'd4, 32'd1000, 32'd3, 1'b1, 5'd4);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("abort_busy", {31'd0, muldiv_busy}, 32'd0);
    check("abort_done", {31'd0, muldiv_done}, 32'd0);
    check("abort_result", muldiv_result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (40) @(negedge clk);
    run("mul_6x7", 3'd0, 32'd6, 32'd7, 1'b1, 5'd2, 32'd42);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
